// File: rtl/dcache_pkg.sv
// Shared types, default geometry and the beat-address helper for the L1 data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    REFILL_REQ,
    REFILL_WAIT,
    RESP,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_MEM_W      = 32;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_SETS       = 64;

  localparam int OFF_W  = $clog2(DEF_LINE_BYTES);
  localparam int IDX_W  = $clog2(DEF_SETS);
  localparam int TAG_W  = DEF_ADDR_W - OFF_W - IDX_W;
  localparam int BEATS  = DEF_LINE_BYTES * 8 / DEF_MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Byte address of one memory beat inside a line starting at base.
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [31:0] beat,
                                            input logic [31:0] beat_bytes);
    return base + beat * beat_bytes;
  endfunction

endpackage

// File: rtl/dcache_beat_engine.sv
// Beat counter and handshake sequencing for line writebacks and refills.
// Handshake: a beat request transfers on a cycle where mem_req_valid_o and
// mem_req_ready_i are both high; valid, address and data hold until then.
// Reads keep one request outstanding and finish on mem_rvalid_i in the wait phase.
module dcache_beat_engine
  import dcache_pkg::*;
#(
  parameter int MEM_W    = DEF_MEM_W,
  parameter int N_BEATS  = BEATS,
  parameter int CNT_BITS = BEAT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic                wait_i,
  input  logic [31:0]         base_i,
  input  logic                mem_req_ready_i,
  input  logic                mem_rvalid_i,
  output logic                mem_req_valid_o,
  output logic                mem_req_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [CNT_BITS-1:0] beat_o,
  output logic                accepted_o,
  output logic                rbeat_o,
  output logic                last_o
);

  logic [CNT_BITS-1:0] beat_q;
  logic                step;

  assign mem_req_valid_o = req_i;
  assign mem_req_we_o    = req_i & we_i;
  assign mem_addr_o      = req_i ? beat_addr(base_i, 32'(beat_q), 32'(MEM_W / 8)) : '0;
  assign accepted_o      = req_i & mem_req_ready_i;
  assign rbeat_o         = wait_i & mem_rvalid_i;
  assign last_o          = (beat_q == CNT_BITS'(N_BEATS - 1));
  assign beat_o          = beat_q;
  assign step            = we_i ? accepted_o : rbeat_o;

  // Beat counter: advances on an accepted write beat or a returned read beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
    end else if (clear_i) begin
      beat_q <= '0;
    end else if (step) begin
      beat_q <= last_o ? '0 : beat_q + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Write-back, write-allocate, direct-mapped L1 data cache with refill/writeback/flush FSM.
// Core handshake: a request is taken on req_valid_i & req_ready_o; every taken
// request produces exactly one resp_valid_o pulse (next cycle for hits).
module dcache_wb_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_W      = DEF_MEM_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int SETS       = DEF_SETS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  input  logic                flush_i,
  output logic                flush_done_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [MEM_W-1:0]    mem_wdata_o,
  output logic [MEM_W/8-1:0]  mem_wstrb_o,
  input  logic                mem_rvalid_i,
  input  logic [MEM_W-1:0]    mem_rdata_i,
  output logic                miss_o,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
);

  localparam int OFF_BITS  = $clog2(LINE_BYTES);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int TAG_BITS  = ADDR_W - OFF_BITS - IDX_BITS;
  localparam int LINE_W    = LINE_BYTES * 8;
  localparam int N_BEATS   = LINE_W / MEM_W;
  localparam int CNT_BITS  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int WORDS     = LINE_W / DATA_W;
  localparam int WSEL_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NBE       = DATA_W / 8;
  localparam int BYTE_BITS = $clog2(NBE);

  state_t state, next_state;

  logic [SETS-1:0]     valid_q, dirty_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [LINE_W-1:0]   data_q [SETS];

  logic [IDX_BITS-1:0]  req_idx, lat_idx, flush_idx, eng_idx;
  logic [TAG_BITS-1:0]  req_tag, lat_tag, eng_tag;
  logic [OFF_BITS-1:0]  req_off;
  logic [WSEL_BITS-1:0] req_wsel, lat_wsel;
  logic                 lat_we, resp_q, flush_done_q, hit, accept;
  logic [NBE-1:0]       lat_be;
  logic [DATA_W-1:0]    lat_wdata, resp_data;
  logic [LINE_W-1:0]    hit_line, fill_line;
  logic [31:0]          eng_base;
  logic                 eng_clear, eng_req, eng_we, eng_wait;
  logic                 eng_acc, eng_rbeat, eng_last;
  logic [CNT_BITS-1:0]  eng_beat;

  assign req_off  = req_addr_i[OFF_BITS-1:0];
  assign req_wsel = WSEL_BITS'(req_off >> BYTE_BITS);
  assign req_idx  = req_addr_i[OFF_BITS +: IDX_BITS];
  assign req_tag  = req_addr_i[ADDR_W-1 -: TAG_BITS];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept   = req_valid_i & req_ready_o;

  assign resp_valid_o = resp_q | (state == RESP);
  assign resp_rdata_o = resp_data;
  assign flush_done_o = flush_done_q;
  assign miss_o       = (state != IDLE);
  assign mem_wstrb_o  = mem_req_we_o ? '1 : '0;
  assign mem_wdata_o  = mem_req_we_o ? data_q[eng_idx][eng_beat*MEM_W +: MEM_W] : '0;

  // Line base seen by the beat engine: victim line for writebacks, new line for refills.
  always_comb begin
    eng_idx  = (state == FLUSH_SCAN || state == FLUSH_WB) ? flush_idx : lat_idx;
    eng_tag  = (state == WB || state == FLUSH_WB) ? tag_q[eng_idx] : lat_tag;
    eng_base = 32'({eng_tag, eng_idx, {OFF_BITS{1'b0}}});
  end

  // Line images after a store hit, and after a refill beat (plus pending store on the last beat).
  always_comb begin
    hit_line = data_q[req_idx];
    for (int b = 0; b < NBE; b++) begin
      if (req_be_i[b]) hit_line[req_wsel*DATA_W + b*8 +: 8] = req_wdata_i[b*8 +: 8];
    end
    fill_line = data_q[lat_idx];
    fill_line[eng_beat*MEM_W +: MEM_W] = mem_rdata_i;
    if (lat_we && eng_last) begin
      for (int b = 0; b < NBE; b++) begin
        if (lat_be[b]) fill_line[lat_wsel*DATA_W + b*8 +: 8] = lat_wdata[b*8 +: 8];
      end
    end
  end

  dcache_beat_engine #(
    .MEM_W    (MEM_W),
    .N_BEATS  (N_BEATS),
    .CNT_BITS (CNT_BITS)
  ) u_beat (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (eng_clear),
    .req_i           (eng_req),
    .we_i            (eng_we),
    .wait_i          (eng_wait),
    .base_i          (eng_base),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_we_o    (mem_req_we_o),
    .mem_addr_o      (mem_addr_o),
    .beat_o          (eng_beat),
    .accepted_o      (eng_acc),
    .rbeat_o         (eng_rbeat),
    .last_o          (eng_last)
  );

  // Next-state logic and per-state engine control.
  always_comb begin
    next_state  = state;
    req_ready_o = 1'b0;
    eng_clear   = 1'b0;
    eng_req     = 1'b0;
    eng_we      = 1'b0;
    eng_wait    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = ~flush_i;
        eng_clear   = 1'b1;
        if (flush_i) next_state = FLUSH_SCAN;
        else if (accept && !hit)
          next_state = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : REFILL_REQ;
      end
      WB: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
        if (eng_acc && eng_last) next_state = REFILL_REQ;
      end
      REFILL_REQ: begin
        eng_req = 1'b1;
        if (eng_acc) next_state = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        eng_wait = 1'b1;
        if (eng_rbeat) next_state = eng_last ? RESP : REFILL_REQ;
      end
      RESP: next_state = IDLE;
      FLUSH_SCAN: begin
        eng_clear = 1'b1;
        if (dirty_q[flush_idx]) next_state = FLUSH_WB;
        else if (&flush_idx) next_state = IDLE;
      end
      FLUSH_WB: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
        if (eng_acc && eng_last) next_state = FLUSH_SCAN;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, line metadata, latched miss request, response and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int i = 0; i < SETS; i++) tag_q[i] <= '0;
      lat_idx      <= '0;
      lat_tag      <= '0;
      lat_wsel     <= '0;
      lat_we       <= 1'b0;
      lat_be       <= '0;
      lat_wdata    <= '0;
      flush_idx    <= '0;
      resp_q       <= 1'b0;
      resp_data    <= '0;
      flush_done_q <= 1'b0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      state        <= next_state;
      resp_q       <= 1'b0;
      flush_done_q <= 1'b0;
      case (state)
        IDLE: begin
          flush_idx <= '0;
          if (accept && hit) begin
            resp_q <= 1'b1;
            if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
            if (req_we_i) dirty_q[req_idx] <= 1'b1;
            else resp_data <= data_q[req_idx][req_wsel*DATA_W +: DATA_W];
          end else if (accept) begin
            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
            lat_idx   <= req_idx;
            lat_tag   <= req_tag;
            lat_wsel  <= req_wsel;
            lat_we    <= req_we_i;
            lat_be    <= req_be_i;
            lat_wdata <= req_wdata_i;
          end
        end
        REFILL_WAIT: begin
          if (eng_rbeat && eng_last) begin
            valid_q[lat_idx] <= 1'b1;
            dirty_q[lat_idx] <= lat_we;
            tag_q[lat_idx]   <= lat_tag;
            if (!lat_we) resp_data <= fill_line[lat_wsel*DATA_W +: DATA_W];
          end
        end
        FLUSH_SCAN: begin
          if (!dirty_q[flush_idx]) begin
            flush_idx <= flush_idx + 1'b1;
            if (&flush_idx) begin
              valid_q      <= '0;
              dirty_q      <= '0;
              flush_done_q <= 1'b1;
            end
          end
        end
        FLUSH_WB: begin
          if (eng_acc && eng_last) dirty_q[flush_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line data storage: store-hit merges and refill beats.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && accept && hit && req_we_i) data_q[req_idx] <= hit_line;
    else if (state == REFILL_WAIT && eng_rbeat) data_q[lat_idx] <= fill_line;
  end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl with a scoreboard on core responses and memory beats.
module tb_dcache_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [18:0] req_addr;
  logic [7:0]  req_be;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        flush, flush_done;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        miss;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_wb_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_be_i        (req_be),
    .req_wdata_i     (req_wdata),
    .resp_valid_o    (resp_valid),
    .resp_rdata_o    (resp_rdata),
    .flush_i         (flush),
    .flush_done_o    (flush_done),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_we_o    (mem_req_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_wstrb_o     (mem_wstrb),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata),
    .miss_o          (miss),
    .hit_cnt_o       (hit_cnt),
    .miss_cnt_o      (miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {check_data, data}
  logic [64:0] exp_resp_q[$];
  // {we, addr, wdata}
  logic [64:0] exp_mem_q[$];

  logic [31:0] mem_store [logic [31:0]];
  int          mem_hs_cnt = 0;
  int          rbeat_cnt = 0;
  int          flush_done_cnt = 0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  logic        in_stall = 1'b0;
  logic [31:0] stall_addr = '0;
  time         last_resp_t = 0;
  time         acc_t = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {16'hA0A0, a[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_rd(input logic [31:0] a);
    exp_mem_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_mem_q.push_back({1'b1, a, d});
  endtask

  task automatic issue(input logic we, input logic [18:0] a, input logic [7:0] be,
                       input logic [63:0] wd);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now("req_accept_timeout", a);
    @(posedge clk); #1;
    acc_t     = $time - 1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_resp_q.size() != 0 || exp_mem_q.size() != 0) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_resp_q.size() != 0 || exp_mem_q.size() != 0)
      fail_now(name, {exp_resp_q.size(), exp_mem_q.size()});
    repeat (2) @(posedge clk);
    #2;
  endtask

  // ---------------- memory responder ----------------
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_delay;

  initial begin
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    pend          = 1'b0;
    pend_addr     = '0;
    pend_delay    = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        if (mem_req_we) mem_store[mem_addr] = mem_wdata;
        else begin
          pend       = 1'b1;
          pend_addr  = mem_addr;
          pend_delay = 1;
        end
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (!rst_n) pend = 1'b0;
      else if (pend) begin
        if (pend_delay == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_read(pend_addr);
          pend       = 1'b0;
          rbeat_cnt++;
        end else pend_delay--;
      end
      if (stall_cnt > 0 && mem_req_valid) stall_cnt--;
      mem_req_ready = (stall_cnt == 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [64:0] e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (resp_valid) begin
          last_resp_t = $time;
          if (exp_resp_q.size() == 0) fail_now("resp_unexpected", resp_rdata);
          else begin
            e = exp_resp_q.pop_front();
            if (e[64]) check("resp_rdata", resp_rdata, e[63:0]);
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          mem_hs_cnt++;
          if (exp_mem_q.size() == 0) fail_now("mem_unexpected", {mem_req_we, mem_addr});
          else begin
            e = exp_mem_q.pop_front();
            check("mem_beat", {mem_req_we, mem_addr, mem_req_we ? mem_wdata : 32'h0}, e);
            if (mem_req_we) check("mem_wstrb", mem_wstrb, 4'hF);
          end
        end
        if (in_stall) begin
          check("stall_valid_held", mem_req_valid, 1'b1);
          check("stall_addr_held", mem_addr, stall_addr);
        end
        if (mem_req_valid && !mem_req_ready) begin
          stall_seen++;
          check("stall_no_resp", resp_valid, 1'b0);
          in_stall   = 1'b1;
          stall_addr = mem_addr;
        end else in_stall = 1'b0;
        if (flush_done) flush_done_cnt++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_rdata"}, resp_rdata, 64'h0);
    check({tag, "_mem_bus"}, {mem_req_valid, mem_req_we, mem_addr, mem_wdata, mem_wstrb}, '0);
    check({tag, "_miss_flush"}, {miss, flush_done}, 2'b00);
    check({tag, "_counters"}, {hit_cnt, miss_cnt}, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  int hs0;
  int rb0;
  int n;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    flush     = 1'b0;
    #12;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Cold load miss with refill of the whole line.
    push_rd(32'h100); push_rd(32'h104); push_rd(32'h108); push_rd(32'h10C);
    exp_resp_q.push_back({1'b1, 64'hA0A0_0104_A0A0_0100});
    issue(1'b0, 19'h00100, 8'h00, 64'h0);
    wait_drain("load_miss_drain");
    check("miss_cnt_1", miss_cnt, 32'd1);
    check("hit_cnt_0", hit_cnt, 32'd0);

    // Load hit on the other word of the same line.
    hs0 = mem_hs_cnt;
    exp_resp_q.push_back({1'b1, 64'hA0A0_010C_A0A0_0108});
    issue(1'b0, 19'h00108, 8'h00, 64'h0);
    wait_drain("load_hit_drain");
    check("hit_latency", 64'(last_resp_t), 64'(acc_t + 5));
    check("hit_no_mem", mem_hs_cnt - hs0, 0);
    check("hit_cnt_1", hit_cnt, 32'd1);

    // Store hit on byte 0, then evict via a conflicting load.
    hs0 = mem_hs_cnt;
    exp_resp_q.push_back({1'b0, 64'h0});
    issue(1'b1, 19'h00100, 8'h01, 64'h0000_0000_0000_00AA);
    wait_drain("store_hit_drain");
    check("store_no_mem", mem_hs_cnt - hs0, 0);
    check("hit_cnt_2", hit_cnt, 32'd2);

    push_wr(32'h100, 32'hA0A0_01AA); push_wr(32'h104, 32'hA0A0_0104);
    push_wr(32'h108, 32'hA0A0_0108); push_wr(32'h10C, 32'hA0A0_010C);
    push_rd(32'h500); push_rd(32'h504); push_rd(32'h508); push_rd(32'h50C);
    exp_resp_q.push_back({1'b1, 64'hA0A0_0504_A0A0_0500});
    issue(1'b0, 19'h00500, 8'h00, 64'h0);
    wait_drain("evict_drain");
    check("miss_cnt_2", miss_cnt, 32'd2);

    // Refill with the memory holding off ready on the first beat.
    stall_cnt = 6;
    push_rd(32'h200); push_rd(32'h204); push_rd(32'h208); push_rd(32'h20C);
    exp_resp_q.push_back({1'b1, 64'hA0A0_0204_A0A0_0200});
    issue(1'b0, 19'h00200, 8'h00, 64'h0);
    wait_drain("stall_drain");
    check("stall_cycles", stall_seen, 5);
    check("miss_cnt_3", miss_cnt, 32'd3);

    // Two dirty lines, then flush.
    exp_resp_q.push_back({1'b0, 64'h0});
    issue(1'b1, 19'h00500, 8'hF0, 64'h1122_3344_5566_7788);
    exp_resp_q.push_back({1'b0, 64'h0});
    issue(1'b1, 19'h00208, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    wait_drain("dirty_drain");
    check("hit_cnt_4", hit_cnt, 32'd4);

    push_wr(32'h500, 32'hA0A0_0500); push_wr(32'h504, 32'h1122_3344);
    push_wr(32'h508, 32'hA0A0_0508); push_wr(32'h50C, 32'hA0A0_050C);
    push_wr(32'h200, 32'hA0A0_0200); push_wr(32'h204, 32'hA0A0_0204);
    push_wr(32'h208, 32'hCAFE_F00D); push_wr(32'h20C, 32'hDEAD_BEEF);
    hs0 = mem_hs_cnt;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n = 0;
    while (flush_done_cnt == 0 && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    if (flush_done_cnt == 0) fail_now("flush_timeout", n);
    wait_drain("flush_drain");
    check("flush_beats", mem_hs_cnt - hs0, 8);
    check("flush_done_pulses", flush_done_cnt, 1);
    check("flush_counters", {hit_cnt, miss_cnt}, {32'd4, 32'd3});

    push_rd(32'h500); push_rd(32'h504); push_rd(32'h508); push_rd(32'h50C);
    exp_resp_q.push_back({1'b1, 64'h1122_3344_A0A0_0500});
    issue(1'b0, 19'h00500, 8'h00, 64'h0);
    wait_drain("post_flush_drain");
    check("miss_cnt_4", miss_cnt, 32'd4);

    // Reset in the middle of a refill.
    rb0 = rbeat_cnt;
    push_rd(32'h300); push_rd(32'h304); push_rd(32'h308); push_rd(32'h30C);
    issue(1'b0, 19'h00300, 8'h00, 64'h0);
    n = 0;
    while (rbeat_cnt < rb0 + 2 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (rbeat_cnt < rb0 + 2) fail_now("rbeat_timeout", rbeat_cnt);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_mem_q.delete();
    exp_resp_q.delete();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hs0 = mem_hs_cnt;
    repeat (6) @(posedge clk);
    #2;
    check("post_reset_quiet", {mem_hs_cnt - hs0, 30'h0, mem_req_valid, miss}, '0);

    push_rd(32'h300); push_rd(32'h304); push_rd(32'h308); push_rd(32'h30C);
    exp_resp_q.push_back({1'b1, 64'hA0A0_0304_A0A0_0300});
    issue(1'b0, 19'h00300, 8'h00, 64'h0);
    wait_drain("reload_drain");
    check("reload_counters", {hit_cnt, miss_cnt}, {32'd0, 32'd1});

    check("queues_empty", exp_resp_q.size() + exp_mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got %0t expected end of test", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_wb_ctrl.md
Name: dcache_wb_ctrl

Overview:
- Parametrised write-back, write-allocate, direct-mapped L1 data cache with its own refill/writeback FSM.
- Successor to the fixed-geometry write-through L1 data path.
- Sits between the core data port (valid/ready request, registered response) and the main-memory bus (per-beat valid/ready request, in-order read return).
- Adds dirty tracking, configurable geometry, byte-strobed stores, full-cache flush and saturating hit/miss counters.

Parameters:
- ADDR_W, 19: core byte-address width.
- DATA_W, 64: core data width (power of 2, ≥ MEM_W).
- MEM_W, 32: memory bus width.
- LINE_BYTES, 16: line size; BEATS = LINE_BYTES*8/MEM_W.
- SETS, 64: number of lines (power of 2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  cache can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_W  byte address, DATA_W/8-aligned
- req_be_i  in  DATA_W/8  store byte enables
- req_wdata_i  in  DATA_W  store data
- resp_valid_o  out  1  one-cycle response pulse (loads and stores)
- resp_rdata_o  out  DATA_W  load data
- flush_i  in  1  pulse: write back all dirty lines and invalidate all lines
- flush_done_o  out  1  one-cycle pulse when flush completes
- mem_req_valid_o  out  1  memory beat request
- mem_req_ready_i  in  1  memory accepts beat
- mem_req_we_o  out  1  write beat
- mem_addr_o  out  32  beat byte address, zero-extended
- mem_wdata_o  out  MEM_W  write data
- mem_wstrb_o  out  MEM_W/8  always all-ones on writes
- mem_rvalid_i  in  1  read beat return
- mem_rdata_i  in  MEM_W  read data
- miss_o  out  1  high whenever FSM is not IDLE
- hit_cnt_o  out  32  saturating hit counter
- miss_cnt_o  out  32  saturating miss counter

Behaviour:
- Address split: offset = log2(LINE_BYTES) bits, index = log2(SETS) bits, tag = remaining bits. Defaults: addr[3:0] offset, addr[9:4] index, addr[18:10] tag.
- Reset (asynchronous, rst_ni low):
  - All valid and dirty bits cleared; FSM to IDLE; counters 0.
  - Every output 0 except req_ready_o = 1.
  - Reset mid-refill or mid-writeback abandons the transfer; no further mem requests are issued.
- States: IDLE, WB, REFILL_REQ, REFILL_WAIT, RESP, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - req_ready_o = 1.
  - On accept with a hit (valid and tag match), in the same cycle: a load captures the DATA_W word; a store merges bytes per req_be_i and sets dirty. resp_valid_o goes high in cycle N+1; hit_cnt increments. Back-to-back hits sustain one request per cycle.
  - On accept with a miss: latch the request, miss_cnt increments, then go to WB if the victim is valid and dirty, else REFILL_REQ.
  - flush_i in IDLE with no simultaneous accept starts a flush.
  - flush_i and req_valid_i in the same cycle: the flush has priority and req_ready_o = 0 that cycle.
- WB:
  - Issues BEATS write beats from beat 0 upward, at addresses {victim_tag, index, beat, byte-offset 0}.
  - Beat counter advances only on mem_req_valid_o & mem_req_ready_i.
  - Address and data are held stable while ready is low.
  - After the last beat, go to REFILL_REQ.
- REFILL_REQ / REFILL_WAIT:
  - One outstanding read: issue the beat request, wait for mem_rvalid_i, write MEM_W into the line, advance the counter.
  - After the last beat: set valid and new tag, clear dirty, apply the pending store merge (setting dirty), go to RESP.
- RESP: resp_valid_o = 1 for one cycle, then IDLE.
- Flush:
  - FLUSH_SCAN walks index 0..SETS-1 at one index per cycle.
  - Each dirty line goes through FLUSH_WB, which uses the same beat engine as WB.
  - All valid and dirty bits are cleared after index SETS-1; flush_done_o pulses, then IDLE.
  - Counters are not affected by a flush.
- Width rules:
  - Load data is little-endian, assembled from consecutive MEM_W beats.
  - Counters saturate at 0xFFFFFFFF.
- Misaligned requests are a caller error; behaviour is undefined, and no assertion is required in RTL.

Decomposition:
- Shared package dcache_pkg holds:
  - the FSM state enum;
  - derived localparams OFF_W, IDX_W, TAG_W, BEATS, BEAT_W;
  - a function for the beat address.
- One sub-module: dcache_beat_engine, a counter plus handshake sequencing BEATS read or write beats for a given line base. It is shared by the WB, refill and flush paths.
- Tag, valid, dirty and data arrays are flops in the top.

Test Plan:
- Reset, load 0x00100 → 4 reads at 0x100, 0x104, 0x108, 0x10C returning A0, A1, A2, A3 → resp_rdata_o = {A1,A0}, miss_cnt = 1.
- Then load 0x00108 → resp_valid_o one cycle after accept, rdata = {A3,A2}, no mem_req_valid_o, hit_cnt = 1.
- Store 0x00100, be = 0x01, wdata low byte 0xAA → no mem traffic; then load 0x00500 (same index, tag 1) → 4 writes to 0x100–0x10C, first wdata = {A0[31:8],0xAA}, wstrb 0xF; then refill reads at 0x500–0x50C.
- Hold mem_req_ready_i low 5 cycles during a refill beat → mem_req_valid_o and mem_addr_o stable, beat counter frozen, no resp_valid_o.
- Make two lines dirty, pulse flush_i → exactly 8 write beats, one flush_done_o pulse; then load either address → miss with refill.
- Assert rst_ni low after refill beat 2 → all outputs at reset values, req_ready_o = 1; a subsequent load of the same address misses.
